// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// Latency: n/a (declarations only). Backpressure: n/a.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Extended operand width: one guard bit so unsigned operands become positive two's complement.
    function automatic int w1_of(input int width);
        return width + 1;
    endfunction

    // Step counter must hold the value W1.
    function automatic int cnt_w_of(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of M, then arithmetic shift right of {A, Q, Q-1}.
// Latency: combinational. Backpressure: none.
module booth_step #(
    parameter int W1 = 5
) (
    input  logic [W1:0]   acc_i,
    input  logic [W1-1:0] q_i,
    input  logic          qm1_i,
    input  logic [W1-1:0] m_i,
    output logic [W1:0]   acc_o,
    output logic [W1-1:0] q_o,
    output logic          qm1_o
);

    logic [W1:0] m_ext;
    logic [W1:0] sum;

    always_comb begin
        m_ext = {m_i[W1-1], m_i};
        unique case ({q_i[0], qm1_i})
            2'b01:   sum = acc_i + m_ext;
            2'b10:   sum = acc_i - m_ext;
            default: sum = acc_i;
        endcase
        acc_o = {sum[W1], sum[W1:1]};
        q_o   = {sum[0], q_i[W1-1:1]};
        qm1_o = q_i[0];
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation, start/busy/done handshake.
// Latency: done WIDTH+1 cycles after the start edge. Backpressure: start is ignored while busy.
module booth_multiplier_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int W1 = w1_of(WIDTH);
    localparam int CW = cnt_w_of(WIDTH);

    state_t             state_q,   state_d;
    logic [W1:0]        acc_q,     acc_d;
    logic [W1-1:0]      q_q,       q_d;
    logic               qm1_q,     qm1_d;
    logic [W1-1:0]      m_q,       m_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [W1:0]        acc_s;
    logic [W1-1:0]      q_s;
    logic               qm1_s;

    booth_step #(
        .W1 (W1)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .acc_o (acc_s),
        .q_o   (q_s),
        .qm1_o (qm1_s)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Mode only decides the extension bit; the datapath is always signed.
                    m_d     = {is_signed & a[WIDTH-1], a};
                    q_d     = {is_signed & b[WIDTH-1], b};
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(W1);
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_s;
                q_d   = q_s;
                qm1_d = qm1_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    product_d = {acc_s[WIDTH-1:0], q_s};
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq at WIDTH=4 and WIDTH=8 with a result/timing scoreboard.
module tb_booth_multiplier_seq;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          ncmp = 0;
    int          nfail = 0;

    logic        reset4 = 1'b1, start4 = 1'b0, is_signed4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  product4;
    logic        busy4, done4;

    logic        reset8 = 1'b1, start8 = 1'b0, is_signed8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] product8;
    logic        busy8, done8;

    exp_t        sb4[$];
    exp_t        sb8[$];

    booth_multiplier_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset4), .start(start4), .is_signed(is_signed4),
        .a(a4), .b(b4), .product(product4), .busy(busy4), .done(done4)
    );

    booth_multiplier_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .is_signed(is_signed8),
        .a(a8), .b(b8), .product(product8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model4(input logic s, input logic [3:0] x, input logic [3:0] y);
        int xi, yi, p;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        p  = xi * yi;
        return p[7:0];
    endfunction

    function automatic logic [15:0] model8(input logic s, input logic [7:0] x, input logic [7:0] y);
        int xi, yi, p;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        p  = xi * yi;
        return p[15:0];
    endfunction

    // Monitors: pop on each done and check value and arrival cycle.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        ncmp++;
        assert (!(busy4 && done4)) else begin nfail++; $error("FAIL busy_done4 busy=%0b done=%0b required not both", busy4, done4); end
        if (done4) begin
            ncmp++;
            assert (sb4.size() != 0) else begin nfail++; $error("FAIL done4_unexpected product=%h required no done", product4); end
            if (sb4.size() != 0) begin
                e = sb4.pop_front();
                ncmp += 2;
                assert (product4 === e.prod[7:0]) else begin nfail++; $error("FAIL prod4 got %h required %h", product4, e.prod[7:0]); end
                assert (cyc === e.cyc) else begin nfail++; $error("FAIL done4_cycle got %0d required %0d", cyc, e.cyc); end
            end
        end
    end

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        ncmp++;
        assert (!(busy8 && done8)) else begin nfail++; $error("FAIL busy_done8 busy=%0b done=%0b required not both", busy8, done8); end
        if (done8) begin
            ncmp++;
            assert (sb8.size() != 0) else begin nfail++; $error("FAIL done8_unexpected product=%h required no done", product8); end
            if (sb8.size() != 0) begin
                e = sb8.pop_front();
                ncmp += 2;
                assert (product8 === e.prod) else begin nfail++; $error("FAIL prod8 got %h required %h", product8, e.prod); end
                assert (cyc === e.cyc) else begin nfail++; $error("FAIL done8_cycle got %0d required %0d", cyc, e.cyc); end
            end
        end
    end

    task automatic launch4(input logic s, input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        is_signed4 = s; a4 = x; b4 = y; start4 = 1'b1;
        e.prod = {8'h00, model4(s, x, y)};
        e.cyc  = cyc + 1 + 5;
        sb4.push_back(e);
        @(negedge clk);
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); is_signed4 = ~s;
    endtask

    task automatic launch8(input logic s, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        is_signed8 = s; a8 = x; b8 = y; start8 = 1'b1;
        e.prod = model8(s, x, y);
        e.cyc  = cyc + 1 + 9;
        sb8.push_back(e);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); is_signed8 = ~s;
    endtask

    task automatic wait_idle4();
        for (int i = 0; i < 30 && sb4.size() != 0; i++) @(negedge clk);
        ncmp++;
        assert (sb4.size() == 0) else begin nfail++; $error("FAIL timeout4 pending=%0d required 0", sb4.size()); end
    endtask

    task automatic wait_idle8();
        for (int i = 0; i < 40 && sb8.size() != 0; i++) @(negedge clk);
        ncmp++;
        assert (sb8.size() == 0) else begin nfail++; $error("FAIL timeout8 pending=%0d required 0", sb8.size()); end
    endtask

    task automatic check4(input string tag, input logic [7:0] got, input logic [7:0] req);
        ncmp++;
        assert (got === req) else begin nfail++; $error("FAIL %s got %h required %h", tag, got, req); end
    endtask

    task automatic check8(input string tag, input logic [15:0] got, input logic [15:0] req);
        ncmp++;
        assert (got === req) else begin nfail++; $error("FAIL %s got %h required %h", tag, got, req); end
    endtask

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        check4("reset_product4", product4, 8'h00);
        check4("reset_busy4", {7'd0, busy4}, 8'h00);
        check4("reset_done4", {7'd0, done4}, 8'h00);
        check8("reset_product8", product8, 16'h0000);
        check8("reset_busy8", {15'd0, busy8}, 16'h0000);
        check8("reset_done8", {15'd0, done8}, 16'h0000);
        reset4 = 1'b0; reset8 = 1'b0;
        @(negedge clk);

        // Exhaustive signed WIDTH=4
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                launch4(1'b1, 4'(i), 4'(j));
                wait_idle4();
                if (i == 8 && j == 8) check4("s4_m8xm8", product4, 8'h40);
                if (i == 7 && j == 8) check4("s4_7xm8", product4, 8'hC8);
            end
        end

        // Unsigned WIDTH=4
        launch4(1'b0, 4'hF, 4'hF); wait_idle4(); check4("u4_15x15", product4, 8'hE1);
        launch4(1'b0, 4'h0, 4'h9); wait_idle4(); check4("u4_0x9", product4, 8'h00);
        launch4(1'b0, 4'h1, 4'hF); wait_idle4(); check4("u4_1x15", product4, 8'h0F);

        // WIDTH=8
        launch8(1'b1, 8'h80, 8'h80); wait_idle8(); check8("s8_m128xm128", product8, 16'h4000);
        launch8(1'b1, 8'hFF, 8'h7F); wait_idle8(); check8("s8_m1x127", product8, 16'hFF81);
        launch8(1'b0, 8'hFF, 8'hFF); wait_idle8(); check8("u8_255x255", product8, 16'hFE01);
        for (int k = 0; k < 12; k++) begin
            launch8(1'(k & 1), 8'($urandom), 8'($urandom));
            wait_idle8();
        end

        // Start while busy is ignored
        launch4(1'b1, 4'h3, 4'h5);
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy4) nb++;
            start4 = (i == 1); a4 = 4'hF; b4 = 4'hF; is_signed4 = 1'b1;
            @(negedge clk);
        end
        start4 = 1'b0;
        check4("busy_len", 8'(nb), 8'd5);
        check4("busy_pending", 8'(sb4.size()), 8'd0);
        check4("busy_product", product4, 8'h0F);

        // Back-to-back start in DONE
        launch4(1'b1, 4'h1, 4'h1);
        wait_idle4();
        check4("b2b_in_done", {7'd0, done4}, 8'h01);
        launch4(1'b1, 4'h2, 4'hD);
        check4("b2b_no_idle", {7'd0, busy4}, 8'h01);
        wait_idle4();
        check4("b2b_product", product4, 8'hFA);

        // Reset mid-run aborts without done
        launch4(1'b1, 4'h3, 4'h3);
        @(negedge clk);
        reset4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        reset4 = 1'b0; start4 = 1'b0;
        check4("rst_product", product4, 8'h00);
        check4("rst_busy", {7'd0, busy4}, 8'h00);
        check4("rst_done", {7'd0, done4}, 8'h00);
        sb4.delete();
        repeat (10) @(negedge clk);
        launch4(1'b1, 4'h4, 4'h4); wait_idle4(); check4("rst_after_4x4", product4, 8'h10);

        repeat (3) @(negedge clk);
        check4("final_pending4", 8'(sb4.size()), 8'd0);
        check4("final_pending8", 8'(sb8.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
